// File: rtl/ctrl_pkg.sv
// rtl/ctrl_pkg.sv - shared state, opcode and control-field encodings for ctrl_fsm_param
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_FETCH  = 4'd1,
    S_DECODE = 4'd2,
    S_NOOP   = 4'd3,
    S_LOAD_A = 4'd4,
    S_LOAD_W = 4'd5,
    S_LOAD_B = 4'd6,
    S_STORE  = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_LDI    = 4'd10,
    S_JPZ    = 4'd11,
    S_HALT   = 4'd12
  } state_t;

  localparam logic [3:0] OP_NOOP  = 4'd0;
  localparam logic [3:0] OP_STORE = 4'd1;
  localparam logic [3:0] OP_LOAD  = 4'd2;
  localparam logic [3:0] OP_ADD   = 4'd3;
  localparam logic [3:0] OP_SUB   = 4'd4;
  localparam logic [3:0] OP_HALT  = 4'd5;
  localparam logic [3:0] OP_LDI   = 4'd6;
  localparam logic [3:0] OP_JPZ   = 4'd7;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;

  localparam logic [1:0] RFS_ALU = 2'b00;
  localparam logic [1:0] RFS_MEM = 2'b01;
  localparam logic [1:0] RFS_IMM = 2'b10;

endpackage

// File: rtl/ctrl_fsm_param.sv
// rtl/ctrl_fsm_param.sv - fetch/decode/execute controller for the 16-bit datapath processor
module ctrl_fsm_param
  import ctrl_pkg::*;
#(
  parameter int OP_W    = 4,
  parameter int RF_AW   = 4,
  parameter int MEM_LAT = 1,
  localparam int IR_W   = OP_W + 3*RF_AW,
  localparam int D_AW   = 2*RF_AW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [IR_W-1:0]    IR,
  input  logic               RF_Ra_zero,
  input  logic               resume,
  output logic               PC_clr,
  output logic               PC_up,
  output logic               PC_ld,
  output logic [D_AW-1:0]    PC_target,
  output logic               IR_ld,
  output logic [D_AW-1:0]    D_addr,
  output logic               D_wr,
  output logic [1:0]         RF_s,
  output logic [RF_AW-1:0]   RF_W_addr,
  output logic               RF_W_en,
  output logic [RF_AW-1:0]   RF_Ra_addr,
  output logic [RF_AW-1:0]   RF_Rb_addr,
  output logic [D_AW-1:0]    RF_imm,
  output logic [2:0]         ALU_s,
  output logic               halted,
  output logic [3:0]         state
);

  state_t     state_q;
  logic [3:0] wait_cnt;

  logic [OP_W-1:0]  op;
  logic [RF_AW-1:0] ra, rb, rd;
  logic [D_AW-1:0]  addr_hi, addr_lo;

  assign op      = IR[IR_W-1 -: OP_W];
  assign ra      = IR[3*RF_AW-1 -: RF_AW];
  assign rb      = IR[2*RF_AW-1 -: RF_AW];
  assign rd      = IR[RF_AW-1:0];
  assign addr_hi = IR[3*RF_AW-1 -: D_AW];
  assign addr_lo = IR[D_AW-1:0];

  assign state = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_INIT;
      wait_cnt <= 4'd0;
    end else begin
      case (state_q)
        S_INIT:   state_q <= S_FETCH;
        S_FETCH:  state_q <= S_DECODE;
        S_DECODE: begin
          case (op)
            OP_W'(OP_STORE): state_q <= S_STORE;
            OP_W'(OP_LOAD):  state_q <= S_LOAD_A;
            OP_W'(OP_ADD):   state_q <= S_ADD;
            OP_W'(OP_SUB):   state_q <= S_SUB;
            OP_W'(OP_HALT):  state_q <= S_HALT;
            OP_W'(OP_LDI):   state_q <= S_LDI;
            OP_W'(OP_JPZ):   state_q <= S_JPZ;
            default:         state_q <= S_NOOP;
          endcase
        end
        S_LOAD_A: begin
          wait_cnt <= 4'(MEM_LAT - 1);
          state_q  <= (MEM_LAT == 1) ? S_LOAD_B : S_LOAD_W;
        end
        // Counter holds the remaining wait cycles including the current one.
        S_LOAD_W: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt <= 4'd1) state_q <= S_LOAD_B;
        end
        S_HALT: if (resume) state_q <= S_FETCH;
        S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB, S_LDI, S_JPZ:
          state_q <= S_FETCH;
        default:  state_q <= S_INIT;
      endcase
    end
  end

  always_comb begin
    PC_clr     = 1'b0;
    PC_up      = 1'b0;
    PC_ld      = 1'b0;
    PC_target  = '0;
    IR_ld      = 1'b0;
    D_addr     = '0;
    D_wr       = 1'b0;
    RF_s       = RFS_ALU;
    RF_W_addr  = '0;
    RF_W_en    = 1'b0;
    RF_Ra_addr = '0;
    RF_Rb_addr = '0;
    RF_imm     = '0;
    ALU_s      = ALU_PASS;
    halted     = 1'b0;
    case (state_q)
      S_INIT:  PC_clr = 1'b1;
      S_FETCH: begin
        IR_ld = 1'b1;
        PC_up = 1'b1;
      end
      S_LOAD_A, S_LOAD_W, S_LOAD_B: begin
        D_addr    = addr_hi;
        RF_s      = RFS_MEM;
        RF_W_addr = rd;
        RF_W_en   = (state_q == S_LOAD_B);
      end
      S_STORE: begin
        D_addr     = addr_lo;
        D_wr       = 1'b1;
        RF_Ra_addr = ra;
      end
      S_ADD, S_SUB: begin
        RF_Ra_addr = ra;
        RF_Rb_addr = rb;
        RF_W_addr  = rd;
        RF_W_en    = 1'b1;
        RF_s       = RFS_ALU;
        ALU_s      = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
      end
      S_LDI: begin
        RF_imm    = addr_hi;
        RF_s      = RFS_IMM;
        RF_W_addr = rd;
        RF_W_en   = 1'b1;
      end
      // Only output that follows an input directly; PC_up stays low here.
      S_JPZ: begin
        RF_Ra_addr = ra;
        PC_target  = addr_lo;
        PC_ld      = RF_Ra_zero;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ctrl_fsm_param.sv
// tb/tb_ctrl_fsm_param.sv - directed-vector bench for ctrl_fsm_param at MEM_LAT 3 and 1
module tb_ctrl_fsm_param;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] IR;
  logic        RF_Ra_zero;
  logic        resume;

  logic       PC_clr, PC_up, PC_ld, IR_ld, D_wr, RF_W_en, halted;
  logic [7:0] PC_target, D_addr, RF_imm;
  logic [1:0] RF_s;
  logic [3:0] RF_W_addr, RF_Ra_addr, RF_Rb_addr, state;
  logic [2:0] ALU_s;

  logic       PC_clr_1, PC_up_1, PC_ld_1, IR_ld_1, D_wr_1, RF_W_en_1, halted_1;
  logic [7:0] PC_target_1, D_addr_1, RF_imm_1;
  logic [1:0] RF_s_1;
  logic [3:0] RF_W_addr_1, RF_Ra_addr_1, RF_Rb_addr_1, state_1;
  logic [2:0] ALU_s_1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ctrl_fsm_param #(.OP_W(4), .RF_AW(4), .MEM_LAT(3)) dut (
    .clk(clk), .rst(rst), .IR(IR), .RF_Ra_zero(RF_Ra_zero), .resume(resume),
    .PC_clr(PC_clr), .PC_up(PC_up), .PC_ld(PC_ld), .PC_target(PC_target),
    .IR_ld(IR_ld), .D_addr(D_addr), .D_wr(D_wr), .RF_s(RF_s),
    .RF_W_addr(RF_W_addr), .RF_W_en(RF_W_en), .RF_Ra_addr(RF_Ra_addr),
    .RF_Rb_addr(RF_Rb_addr), .RF_imm(RF_imm), .ALU_s(ALU_s),
    .halted(halted), .state(state)
  );

  ctrl_fsm_param #(.OP_W(4), .RF_AW(4), .MEM_LAT(1)) dut_l1 (
    .clk(clk), .rst(rst), .IR(IR), .RF_Ra_zero(RF_Ra_zero), .resume(resume),
    .PC_clr(PC_clr_1), .PC_up(PC_up_1), .PC_ld(PC_ld_1), .PC_target(PC_target_1),
    .IR_ld(IR_ld_1), .D_addr(D_addr_1), .D_wr(D_wr_1), .RF_s(RF_s_1),
    .RF_W_addr(RF_W_addr_1), .RF_W_en(RF_W_en_1), .RF_Ra_addr(RF_Ra_addr_1),
    .RF_Rb_addr(RF_Rb_addr_1), .RF_imm(RF_imm_1), .ALU_s(ALU_s_1),
    .halted(halted_1), .state(state_1)
  );

  // 48-bit packed view of every control output of the MEM_LAT=3 instance, PC_clr at bit 47
  function automatic logic [63:0] outs();
    return {16'h0, PC_clr, PC_up, PC_ld, PC_target, IR_ld, D_addr, D_wr, RF_s,
            RF_W_addr, RF_W_en, RF_Ra_addr, RF_Rb_addr, RF_imm, ALU_s, halted};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset, then step to the first execute state of whatever IR holds.
  task automatic reset_to_exec(input logic [15:0] instr);
    rst = 1'b1;
    IR  = instr;
    tick();
    rst = 1'b0;
    tick();
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1;
    IR = 16'h0000;
    RF_Ra_zero = 1'b0;
    resume = 1'b0;

    // 1: reset then ADD
    tick();
    tick();
    check("reset_state", state, 4'd0);
    check("init_outs", outs(), 64'h0000_8000_0000_0000);
    IR  = 16'h3121;
    rst = 1'b0;
    tick();
    check("fetch_state", state, 4'd1);
    check("fetch_ld_up", {IR_ld, PC_up, PC_clr}, 3'b110);
    tick();
    check("decode_outs", outs(), 64'h0);
    tick();
    check("add_state", state, 4'd8);
    check("add_ra_rb_wa", {RF_Ra_addr, RF_Rb_addr, RF_W_addr}, 12'h121);
    check("add_wen_alu_s", {RF_W_en, ALU_s, RF_s}, 6'b1_001_00);
    tick();
    check("add_to_fetch", state, 4'd1);

    // 2: LOAD at MEM_LAT 3 and MEM_LAT 1 side by side
    reset_to_exec(16'h2A53);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("ld3_wait%0d", i), {D_addr, RF_s, RF_W_en}, {8'hA5, 2'b01, 1'b0});
      check($sformatf("ld3_state%0d", i), state, (i == 0) ? 4'd4 : 4'd5);
      if (i == 0) check("ld1_a", state_1, 4'd4);
      if (i == 1) check("ld1_b", {state_1, RF_W_en_1, RF_W_addr_1, D_addr_1}, {4'd6, 1'b1, 4'd3, 8'hA5});
      if (i == 2) check("ld1_fetch", state_1, 4'd1);
      tick();
    end
    check("ld3_b", {state, RF_W_en, RF_W_addr, D_addr, RF_s}, {4'd6, 1'b1, 4'd3, 8'hA5, 2'b01});
    tick();
    check("ld3_fetch", state, 4'd1);

    // 3: LDI then STORE
    reset_to_exec(16'h6FF7);
    check("ldi_state", state, 4'd10);
    check("ldi_outs", {RF_imm, RF_s, RF_W_addr, RF_W_en}, {8'hFF, 2'b10, 4'd7, 1'b1});
    tick();
    IR = 16'h14C8;
    tick();
    tick();
    check("store_state", state, 4'd7);
    check("store_outs", {D_addr, D_wr, RF_Ra_addr, RF_W_en}, {8'hC8, 1'b1, 4'd4, 1'b0});

    // 4: JPZ taken and not taken
    tick();
    IR = 16'h7230;
    tick();
    tick();
    RF_Ra_zero = 1'b1;
    #1;
    check("jpz_state", state, 4'd11);
    check("jpz_taken", {PC_ld, PC_up, PC_target, RF_Ra_addr}, {1'b1, 1'b0, 8'h30, 4'd2});
    RF_Ra_zero = 1'b0;
    #1;
    check("jpz_not_taken", {PC_ld, PC_up}, 2'b00);
    tick();
    check("jpz_to_fetch", state, 4'd1);

    // 5: HALT holds through IR changes until resume
    IR = 16'h5000;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      if (i == 3) IR = 16'h1ABB;
      #1;
      check($sformatf("halt_c%0d", i), {state, halted, D_wr}, {4'd12, 1'b1, 1'b0});
      tick();
    end
    resume = 1'b1;
    tick();
    resume = 1'b0;
    check("resume_fetch", {state, halted}, {4'd1, 1'b0});

    // rst wins over resume in HALT
    IR = 16'h5000;
    tick();
    tick();
    check("halt_again", state, 4'd12);
    rst = 1'b1;
    resume = 1'b1;
    tick();
    rst = 1'b0;
    resume = 1'b0;
    check("rst_over_resume", state, 4'd0);

    // 6: reset in LOAD_W, then unknown opcode acts as NOOP
    reset_to_exec(16'h2A53);
    tick();
    check("mid_load_w", state, 4'd5);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_state", state, 4'd0);
    check("mid_rst_cnt", dut.wait_cnt, 4'd0);
    IR = 16'hE123;
    tick();
    tick();
    tick();
    check("noop_state", state, 4'd3);
    check("noop_outs", outs(), 64'h0);
    tick();
    check("noop_to_fetch", state, 4'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ctrl_fsm_param.md
Name: ctrl_fsm_param

Overview:
Parametrised next-generation controller FSM for the 16-bit datapath processor. It sequences fetch, decode and execute and drives the PC, IR, data memory, register file and ALU control lines. Compared with the first-generation controller it adds:
- a synchronous reset;
- configurable field widths;
- a configurable data-memory read latency;
- load-immediate (LDI) and jump-if-zero (JPZ) instructions;
- a resumable HALT.

Parameters:
- OP_W, 4, opcode field width (IR MSBs).
- RF_AW, 4, register-file address width.
- MEM_LAT, 1, data-memory read latency in cycles; legal range 1..15.
- Derived localparam IR_W = OP_W + 3*RF_AW (16 at defaults).
- Derived localparam D_AW = 2*RF_AW (8 at defaults).

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- IR  in  IR_W  current instruction register contents.
- RF_Ra_zero  in  1  high when the register-file A read port equals zero.
- resume  in  1  single-cycle pulse; leaves HALT.
- PC_clr  out  1  clear PC.
- PC_up  out  1  increment PC.
- PC_ld  out  1  load PC from PC_target.
- PC_target  out  D_AW  jump target address.
- IR_ld  out  1  load IR from instruction memory.
- D_addr  out  D_AW  data-memory address.
- D_wr  out  1  data-memory write enable.
- RF_s  out  2  write-data mux select: 00 = ALU, 01 = memory, 10 = immediate.
- RF_W_addr  out  RF_AW  register-file write address.
- RF_W_en  out  1  register-file write enable.
- RF_Ra_addr  out  RF_AW  register-file read port A address.
- RF_Rb_addr  out  RF_AW  register-file read port B address.
- RF_imm  out  D_AW  immediate write data.
- ALU_s  out  3  ALU select: 000 = pass, 001 = add, 010 = sub.
- halted  out  1  high while in HALT.
- state  out  4  current state encoding, for debug.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. When rst is high at a posedge, the state becomes INIT regardless of the current state, including mid-LOAD or in HALT. The wait counter clears to 0.
- Output style: outputs are combinational decodes of state (Moore, except PC_ld in JPZ).
- Default output values: every output is 0 in every state unless listed below. The INIT state therefore drives PC_clr = 1 and all other outputs 0.
- IR field names:
  - op = IR[IR_W-1 -: OP_W]
  - ra = IR[3*RF_AW-1 -: RF_AW]
  - rb = IR[2*RF_AW-1 -: RF_AW]
  - rd = IR[RF_AW-1:0]
  - addr_hi = IR[3*RF_AW-1 -: D_AW]
  - addr_lo = IR[D_AW-1:0]
- Opcodes: NOOP = 0, STORE = 1, LOAD = 2, ADD = 3, SUB = 4, HALT = 5, LDI = 6, JPZ = 7. Any other value decodes as NOOP.
- INIT: PC_clr = 1 -> FETCH.
- FETCH: IR_ld = 1, PC_up = 1 -> DECODE.
- DECODE: no outputs. Branches on op to the matching execute state; unknown opcodes go to NOOP.
- NOOP: -> FETCH.
- LOAD_A: D_addr = addr_hi, RF_s = 01, RF_W_addr = rd. Counter loads MEM_LAT-1.
  - If MEM_LAT = 1 -> LOAD_B; else -> LOAD_W.
- LOAD_W: same outputs as LOAD_A. Counter decrements each cycle; -> LOAD_B when the counter reaches 1.
  - Total cycles spent in LOAD_A plus LOAD_W equals MEM_LAT.
- LOAD_B: same outputs as LOAD_A plus RF_W_en = 1 -> FETCH.
- STORE: D_addr = addr_lo, D_wr = 1, RF_Ra_addr = ra -> FETCH.
- ADD / SUB: RF_Ra_addr = ra, RF_Rb_addr = rb, RF_W_addr = rd, RF_W_en = 1, RF_s = 00. ALU_s = 001 for ADD, 010 for SUB. -> FETCH.
- LDI: RF_imm = addr_hi, RF_s = 10, RF_W_addr = rd, RF_W_en = 1 -> FETCH.
- JPZ: RF_Ra_addr = ra, PC_target = addr_lo, PC_ld = RF_Ra_zero (combinational) -> FETCH.
  - PC_up is never asserted in the same cycle as PC_ld.
- HALT: halted = 1; remains in HALT while resume = 0. resume = 1 -> FETCH.
  - IR changes while halted are ignored.
  - rst has priority over resume.
- Latency per instruction, counted FETCH to FETCH: 3 cycles for ALU/STORE/LDI/JPZ/NOOP; 3 + MEM_LAT cycles for LOAD.
- Illegal state encodings recover to INIT on the next clock.
- IR is sampled only in DECODE and in the execute states. It must be held stable from DECODE to the end of the instruction.

Decomposition:
- Package ctrl_pkg holds:
  - the state_t enum (INIT, FETCH, DECODE, NOOP, LOAD_A, LOAD_W, LOAD_B, STORE, ADD, SUB, LDI, JPZ, HALT; 4-bit);
  - the opcode constants;
  - the ALU_s constants;
  - the RF_s mux constants.
- No sub-module. The latency counter is a 4-bit register inside ctrl_fsm_param.

Test Plan:
1. Reset, then ADD: rst = 1 for 2 cycles, then IR = 16'h3121. Expect PC_clr = 1 in cycle 1 after reset, then FETCH (IR_ld = PC_up = 1), DECODE, then ADD with Ra = 1, Rb = 2, W_addr = 1, W_en = 1, ALU_s = 001.
2. LOAD with MEM_LAT = 3, IR = 16'h2A53: D_addr = 8'hA5 and RF_s = 01 held 3 cycles with W_en = 0. The 4th execute cycle (LOAD_B) has W_en = 1, W_addr = 3. Next state is FETCH. Repeat with MEM_LAT = 1: LOAD_A then LOAD_B only.
3. LDI and STORE: IR = 16'h6FF7 gives RF_imm = 8'hFF, RF_s = 10, W_addr = 7, W_en = 1. IR = 16'h14C8 gives D_addr = 8'hC8, D_wr = 1, Ra = 4.
4. JPZ, IR = 16'h7230: with RF_Ra_zero = 1, PC_ld = 1 and PC_target = 8'h30. With RF_Ra_zero = 0, PC_ld = 0. Both cases return to FETCH, and PC_up = 0 in JPZ.
5. HALT/resume: IR = 16'h5000 gives halted = 1 for 10 cycles. Changing IR to 16'h1ABB meanwhile gives D_wr = 0. A resume pulse enters FETCH on the next cycle.
6. Reset mid-op: assert rst during LOAD_W; the next state is INIT and the counter is 0. Opcode 4'hE decodes to NOOP with all outputs 0.
